regfile_2r1w: RTL and testbench



---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_wr_decoder.sv | 16 +
 rtl/regfile_2r1w.sv | 51 +++++
 tb/tb_regfile_2r1w.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and the register address type.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_NUM = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_wr_decoder.sv
// regfile_wr_decoder: one-hot write strobe from a register address, $0 strobe tied low.
module regfile_wr_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [2**ADDR_W-1:0]   we
);
  always_comb begin
    we = '0;
    we[addr] = en;
    we[0] = 1'b0;
  end
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32x32 MIPS register file, two registered read ports, one write port.
// Defining REGFILE_BYPASS_EN makes same-edge read/write of one address return the new data.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0]  we;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] dout1_q, dout1_d, dout2_q, dout2_d;
  regfile_wr_decoder #(.ADDR_W(ADDR_W)) u_dec (.addr(Awr), .en(WrEn), .we(we));
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < DEPTH; i++) regs_d[i] = we[i] ? Din : regs_q[i];
  end
  // we[0] is never set, so bypass can never leak data onto a $0 read
  always_comb begin
    dout1_d = (Ard1 == '0) ? '0 : regs_q[Ard1];
    dout2_d = (Ard2 == '0) ? '0 : regs_q[Ard2];
`ifdef REGFILE_BYPASS_EN
    dout1_d = we[Ard1] ? Din : dout1_d;
    dout2_d = we[Ard2] ? Din : dout2_d;
`endif
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
    end else begin
      regs_q <= regs_d;
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
    end
  end
  assign Dout1 = dout1_q;
  assign Dout2 = dout2_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed and random checks of regfile_2r1w against an array model.
module tb_regfile_2r1w;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  Ard1, Ard2, Awr;
  logic [31:0] Din;
  logic        WrEn;
  logic [31:0] Dout1, Dout2;
  logic [31:0] model [32];
  logic [31:0] e1, e2;
  int vectors = 0;
  int miscompares = 0;

  regfile_2r1w dut (.Clk(Clk), .Rst_n(Rst_n), .Ard1(Ard1), .Ard2(Ard2), .Awr(Awr),
                    .Din(Din), .WrEn(WrEn), .Dout1(Dout1), .Dout2(Dout2));

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rd_exp(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && WrEn && a == Awr) return Din;
    return model[a];
  endfunction

  // Predict both outputs for the coming edge, apply the write to the model, then advance.
  task automatic step();
    e1 = rd_exp(Ard1);
    e2 = rd_exp(Ard2);
    if (WrEn && Awr != 0) model[Awr] = Din;
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic idle();
    WrEn = 0; Awr = 0; Din = 0; Ard1 = 0; Ard2 = 0;
  endtask

  task automatic test_reset();
    idle();
    clear_model();
    Rst_n = 0;
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (Dout1 !== 32'h0 || Dout2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_init dout1=%h dout2=%h want 0/0", Dout1, Dout2);
    end
    Rst_n = 1;
    WrEn = 1; Awr = 5; Din = 32'hDEADBEEF;
    step();
    WrEn = 0; Ard1 = 5; Ard2 = 5;
    step();
    vectors++;
    if (Dout1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL reset_prewrite dout1=%h want deadbeef", Dout1);
    end
    #2 Rst_n = 0;
    clear_model();
    #1;
    vectors++;
    if (Dout1 !== 32'h0 || Dout2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async dout1=%h dout2=%h want 0/0", Dout1, Dout2);
    end
    #1 Rst_n = 1;
    Ard1 = 5; Ard2 = 0;
    WrEn = 1; Awr = 9; Din = 32'hCAFE_0009;
    step();
    vectors++;
    if (Dout1 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_cleared dout1=%h want 0", Dout1);
    end
    WrEn = 0; Ard1 = 9;
    step();
    vectors++;
    if (Dout1 !== 32'hCAFE_0009) begin
      miscompares++;
      $display("FAIL reset_first_write dout1=%h want cafe0009", Dout1);
    end
  endtask

  task automatic test_basic();
    idle();
    WrEn = 1; Awr = 15; Din = 32'h0000_00AA;
    step();
    WrEn = 0; Ard1 = 15; Ard2 = 0;
    step();
    vectors++;
    if (Dout1 !== 32'h0000_00AA || Dout2 !== 32'h0) begin
      miscompares++;
      $display("FAIL basic dout1=%h dout2=%h want 000000aa/0", Dout1, Dout2);
    end
  endtask

  task automatic test_zero();
    idle();
    WrEn = 1; Awr = 0; Din = 32'hFFFF_FFFF;
    step();
    vectors++;
    if (Dout1 !== 32'h0 || Dout2 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_same_edge dout1=%h dout2=%h want 0/0", Dout1, Dout2);
    end
    WrEn = 0;
    step();
    vectors++;
    if (Dout1 !== 32'h0 || Dout2 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_read dout1=%h dout2=%h want 0/0", Dout1, Dout2);
    end
  endtask

  task automatic test_dual();
    idle();
    WrEn = 1; Awr = 31; Din = 32'h1234_5678;
    step();
    WrEn = 0; Ard1 = 31; Ard2 = 31;
    step();
    vectors++;
    if (Dout1 !== 32'h1234_5678 || Dout2 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL dual dout1=%h dout2=%h want 12345678", Dout1, Dout2);
    end
  endtask

  task automatic test_collision();
    idle();
    WrEn = 1; Awr = 7; Din = 32'h1;
    step();
    Din = 32'h2; Ard1 = 7; Ard2 = 0;
    step();
    vectors++;
    if (Dout1 !== (BYP ? 32'h2 : 32'h1)) begin
      miscompares++;
      $display("FAIL collision dout1=%h want %h", Dout1, BYP ? 32'h2 : 32'h1);
    end
    WrEn = 0;
    step();
    vectors++;
    if (Dout1 !== 32'h2) begin
      miscompares++;
      $display("FAIL collision_after dout1=%h want 2", Dout1);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    WrEn = 1;
    for (int i = 1; i < 32; i++) begin
      Awr = 5'(i); Din = i * 32'h0101_0101;
      step();
    end
    WrEn = 0;
    for (int i = 1; i < 32; i++) begin
      Ard1 = 5'(i); Ard2 = 5'(32 - i);
      step();
      vectors++;
      if (Dout1 !== i * 32'h0101_0101 || Dout2 !== (32 - i) * 32'h0101_0101) begin
        miscompares++;
        $display("FAIL sweep i=%0d dout1=%h want %h dout2=%h want %h", i, Dout1,
                 i * 32'h0101_0101, Dout2, (32 - i) * 32'h0101_0101);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      WrEn = 1'($urandom);
      Awr = 5'($urandom_range(0, 31));
      Din = $urandom;
      Ard1 = ($urandom_range(0, 3) == 0) ? Awr : 5'($urandom_range(0, 31));
      Ard2 = ($urandom_range(0, 3) == 0) ? Awr : 5'($urandom_range(0, 31));
      step();
      vectors++;
      if (Dout1 !== e1 || Dout2 !== e2) begin
        miscompares++;
        $display("FAIL random n=%0d dout1=%h want %h dout2=%h want %h", n, Dout1, e1, Dout2, e2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_dual();
    test_collision();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
